// File: rtl/alarm_ring_controller_if.sv
// Alarm sequencer bus: time/alarm inputs, buttons, and ring status/speaker outputs.
// Latency: none (wires only).
// Backpressure: none; master drives inputs every cycle, slave drives registered status.
interface alarm_ring_controller_if;
    logic [7:0] real_hours;
    logic [7:0] real_mins;
    logic [7:0] alarm_hours;
    logic [7:0] alarm_mins;
    logic       alarm_enabled;
    logic       btn_snooze;
    logic       btn_dismiss;
    logic       alarm_triggered;
    logic       snoozing;
    logic [1:0] snooze_count;
    logic       speaker_out;

    modport master (
        output real_hours, real_mins, alarm_hours, alarm_mins,
        output alarm_enabled, btn_snooze, btn_dismiss,
        input  alarm_triggered, snoozing, snooze_count, speaker_out
    );

    modport slave (
        input  real_hours, real_mins, alarm_hours, alarm_mins,
        input  alarm_enabled, btn_snooze, btn_dismiss,
        output alarm_triggered, snoozing, snooze_count, speaker_out
    );
endinterface

// File: rtl/alarm_ring_controller.sv
// Alarm sequencer: arm, ring on time match, snooze/dismiss, ring timeout, same-minute holdoff.
// Latency: state and every output registered, 1 cycle after the causing input.
// Backpressure: none; button pulses sampled every cycle, ignored outside RINGING/SNOOZE.
// Option macro BEEP_PATTERN_EN: tone audible only in the first half of each second.
module alarm_ring_controller #(
    parameter int TONE_DIV     = 25_000,
    parameter int SEC_DIV      = 50_000_000,
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_SECS  = 300,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    alarm_ring_controller_if.slave  io_alarm
);
    localparam int SEC_W  = $clog2(SEC_DIV);
    localparam int TONE_W = $clog2(TONE_DIV);
    localparam int RING_W = $clog2(RING_TIMEOUT + 1);
    localparam int SNZ_W  = $clog2(SNOOZE_SECS + 1);

    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_DIV - 1);
    localparam logic [SEC_W-1:0]  SEC_ONE   = SEC_W'(1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
    localparam logic [TONE_W-1:0] TONE_ONE  = TONE_W'(1);
    localparam logic [RING_W-1:0] RING_LIM  = RING_W'(RING_TIMEOUT);
    localparam logic [RING_W-1:0] RING_ONE  = RING_W'(1);
    localparam logic [SNZ_W-1:0]  SNZ_LIM   = SNZ_W'(SNOOZE_SECS);
    localparam logic [SNZ_W-1:0]  SNZ_ONE   = SNZ_W'(1);
    localparam logic [1:0]        MAX_SN    = 2'(MAX_SNOOZE);
`ifdef BEEP_PATTERN_EN
    localparam logic [SEC_W-1:0]  SEC_HALF  = SEC_W'(SEC_DIV / 2);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_RINGING, S_SNOOZE, S_HOLDOFF
    } state_t;

    state_t            r_state, w_state_next;
    logic [SEC_W-1:0]  r_sec_cnt, w_sec_next;
    logic [RING_W-1:0] r_ring_tmr, w_ring_next, w_ring_inc;
    logic [SNZ_W-1:0]  r_snz_tmr, w_snz_next, w_snz_inc;
    logic [1:0]        r_snooze_count, w_count_next;
    logic [TONE_W-1:0] r_tone_cnt, w_tone_cnt_next;
    logic              r_tone, w_tone_next;
    logic              r_speaker, w_speaker_next;
    logic              r_alarm_triggered, r_snoozing;
    logic              w_match, w_tick, w_ring_stay;

    assign w_match    = (io_alarm.real_hours == io_alarm.alarm_hours) &&
                        (io_alarm.real_mins  == io_alarm.alarm_mins);
    assign w_tick     = (r_sec_cnt == SEC_LAST);
    assign w_ring_inc = r_ring_tmr + RING_ONE;
    assign w_snz_inc  = r_snz_tmr + SNZ_ONE;

    // Next-state, timers and snooze count; disable overrides everything below reset.
    always_comb begin
        w_state_next = r_state;
        w_sec_next   = w_tick ? '0 : r_sec_cnt + SEC_ONE;
        w_ring_next  = r_ring_tmr;
        w_snz_next   = r_snz_tmr;
        w_count_next = r_snooze_count;
        case (r_state)
            S_IDLE: begin
                if (io_alarm.alarm_enabled)
                    w_state_next = w_match ? S_HOLDOFF : S_ARMED;
            end
            S_ARMED: begin
                if (w_match) begin
                    w_state_next = S_RINGING;
                    w_sec_next   = '0;
                    w_ring_next  = '0;
                    w_count_next = '0;
                end
            end
            S_RINGING: begin
                if (io_alarm.btn_dismiss) begin
                    w_state_next = S_HOLDOFF;
                end else if (io_alarm.btn_snooze && (r_snooze_count < MAX_SN)) begin
                    w_state_next = S_SNOOZE;
                    w_count_next = r_snooze_count + 2'd1;
                    w_snz_next   = '0;
                    w_sec_next   = '0;
                end else if (w_tick) begin
                    if (w_ring_inc >= RING_LIM) w_state_next = S_HOLDOFF;
                    else                        w_ring_next  = w_ring_inc;
                end
            end
            S_SNOOZE: begin
                if (io_alarm.btn_dismiss) begin
                    w_state_next = S_HOLDOFF;
                end else if (w_tick) begin
                    if (w_snz_inc >= SNZ_LIM) begin
                        // Re-ring is unconditional: the event outlives the matching minute.
                        w_state_next = S_RINGING;
                        w_ring_next  = '0;
                        w_sec_next   = '0;
                    end else begin
                        w_snz_next = w_snz_inc;
                    end
                end
            end
            S_HOLDOFF: begin
                if (!w_match) w_state_next = S_ARMED;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (!io_alarm.alarm_enabled) begin
            w_state_next = S_IDLE;
            w_count_next = '0;
        end
    end

    // Tone divider runs only while staying in RINGING; cleared and silent otherwise.
    always_comb begin
        w_ring_stay     = (r_state == S_RINGING) && (w_state_next == S_RINGING);
        w_tone_cnt_next = '0;
        w_tone_next     = 1'b0;
        if (w_ring_stay) begin
            w_tone_cnt_next = (r_tone_cnt == TONE_LAST) ? '0 : r_tone_cnt + TONE_ONE;
            w_tone_next     = (r_tone_cnt == TONE_LAST) ? ~r_tone : r_tone;
        end
`ifdef BEEP_PATTERN_EN
        w_speaker_next = w_tone_next && (w_sec_next < SEC_HALF);
`else
        w_speaker_next = w_tone_next;
`endif
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_sec_cnt         <= '0;
            r_ring_tmr        <= '0;
            r_snz_tmr         <= '0;
            r_snooze_count    <= '0;
            r_tone_cnt        <= '0;
            r_tone            <= 1'b0;
            r_speaker         <= 1'b0;
            r_alarm_triggered <= 1'b0;
            r_snoozing        <= 1'b0;
        end else begin
            r_state           <= w_state_next;
            r_sec_cnt         <= w_sec_next;
            r_ring_tmr        <= w_ring_next;
            r_snz_tmr         <= w_snz_next;
            r_snooze_count    <= w_count_next;
            r_tone_cnt        <= w_tone_cnt_next;
            r_tone            <= w_tone_next;
            r_speaker         <= w_speaker_next;
            r_alarm_triggered <= (w_state_next == S_RINGING);
            r_snoozing        <= (w_state_next == S_SNOOZE);
        end
    end

    assign io_alarm.alarm_triggered = r_alarm_triggered;
    assign io_alarm.snoozing        = r_snoozing;
    assign io_alarm.snooze_count    = r_snooze_count;
    assign io_alarm.speaker_out     = r_speaker;
endmodule
